// File: rtl/reg_writeback_ctrl_pkg.sv
// reg_writeback_ctrl_pkg: shared widths, zero-register address and write-source encoding
package reg_writeback_ctrl_pkg;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam int NUM_REGS = 16;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;
  typedef enum logic [1:0] {SRC_NONE, SRC_ALU, SRC_MEM} wb_src_e;
endpackage

// File: rtl/reg_writeback_ctrl_wb_fifo.sv
// wb_fifo: synchronous FIFO buffering memory results ahead of the write port
module wb_fifo
  import reg_writeback_ctrl_pkg::*;
#(
  parameter int W = ADDR_W + DATA_W,
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          nClear,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  // next pointers, occupancy and storage; push and pop may share an edge
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = din;
    wr_d = push ? wr_q + 1'b1 : wr_q;
    rd_d = pop ? rd_q + 1'b1 : rd_q;
    count_d = count_q + CW'(push) - CW'(pop);
  end
  // pointers clear on nClear; storage contents need no reset
  always_ff @(posedge clk) begin
    if (!nClear) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
    mem_q <= mem_d;
  end
  assign dout = mem_q[rd_q];
  assign count = count_q;
endmodule

// File: rtl/reg_writeback_ctrl.sv
// reg_writeback_ctrl: arbitrates ALU and buffered load results onto the register file write port
module reg_writeback_ctrl
  import reg_writeback_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                nClear,
  input  logic                alu_valid,
  input  logic [ADDR_W-1:0]   alu_addr,
  input  logic [DATA_W-1:0]   alu_data,
  output logic                alu_stall,
  input  logic                mem_valid,
  output logic                mem_ready,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_data,
  input  logic                rsv_valid,
  input  logic [ADDR_W-1:0]   rsv_addr,
  output logic [ADDR_W-1:0]   Caddr,
  output logic [DATA_W-1:0]   C,
  output logic                load,
  output logic [NUM_REGS-1:0] pending
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] fifo_count;
  logic [ADDR_W+DATA_W-1:0] fifo_head;
  logic nonempty, push, pop;
  wb_src_e src;
  logic [ADDR_W-1:0] win_addr, caddr_q, caddr_d;
  logic [DATA_W-1:0] win_data, c_q, c_d;
  logic load_q, load_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [NUM_REGS-1:0] pending_q, pending_d;
  assign nonempty = fifo_count != '0;
  assign mem_ready = nClear && (fifo_count < CW'(FIFO_DEPTH));
  assign alu_stall = nClear && alu_valid && nonempty && (starve_q == SW'(STARVE_LIMIT));
  assign push = mem_valid && mem_ready;
  wb_fifo #(.W(ADDR_W + DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .nClear(nClear),
    .push(push),
    .pop(pop),
    .din({mem_addr, mem_data}),
    .dout(fifo_head),
    .count(fifo_count)
  );
  // pick the winner, form the next write, starvation count and pending set
  always_comb begin
    src = (alu_valid && !alu_stall) ? SRC_ALU : nonempty ? SRC_MEM : SRC_NONE;
    pop = nClear && src == SRC_MEM;
    win_addr = src == SRC_ALU ? alu_addr : fifo_head[ADDR_W+DATA_W-1:DATA_W];
    win_data = src == SRC_ALU ? alu_data : fifo_head[DATA_W-1:0];
    load_d = src != SRC_NONE && win_addr != ZERO_ADDR;
    caddr_d = load_d ? win_addr : caddr_q;
    c_d = load_d ? win_data : c_q;
    starve_d = (!nonempty || pop) ? '0 :
               (src == SRC_ALU && starve_q != SW'(STARVE_LIMIT)) ? starve_q + 1'b1 : starve_q;
    pending_d = pending_q;
    if (load_d) pending_d[win_addr] = 1'b0;
    if (rsv_valid && rsv_addr != ZERO_ADDR) pending_d[rsv_addr] = 1'b1;
  end
  // register the write port, starvation counter and scoreboard
  always_ff @(posedge clk) begin
    if (!nClear) begin
      caddr_q <= '0;
      c_q <= '0;
      load_q <= 1'b0;
      starve_q <= '0;
      pending_q <= '0;
    end else begin
      caddr_q <= caddr_d;
      c_q <= c_d;
      load_q <= load_d;
      starve_q <= starve_d;
      pending_q <= pending_d;
    end
  end
  assign Caddr = caddr_q;
  assign C = c_q;
  assign load = load_q;
  assign pending = pending_q;
endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// tb_reg_writeback_ctrl: scoreboard bench for the register writeback controller
module tb_reg_writeback_ctrl;
  logic clk = 1'b0;
  logic nClear, alu_valid, mem_valid, rsv_valid;
  logic [3:0] alu_addr, mem_addr, rsv_addr, Caddr;
  logic [15:0] alu_data, mem_data, C, pending;
  logic alu_stall, mem_ready, load;
  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;
  logic [19:0] exp_q [$];
  logic [19:0] mem_model_q [$];
  logic [19:0] mon_e;

  always #5 clk = ~clk;

  reg_writeback_ctrl dut (
    .clk(clk), .nClear(nClear),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_stall(alu_stall),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .Caddr(Caddr), .C(C), .load(load), .pending(pending)
  );

  // every register file write must match the next expected write in order
  always @(negedge clk) begin
    if (mon_en && load !== 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_write: got unexpected write load=%b Caddr=%0d C=%h, none expected", load, Caddr, C);
      end else begin
        mon_e = exp_q.pop_front();
        if ({load, Caddr, C} !== {1'b1, mon_e}) begin
          errors++;
          $display("FAIL wb_write: got load=%b Caddr=%0d C=%h expected Caddr=%0d C=%h", load, Caddr, C, mon_e[19:16], mon_e[15:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; alu_addr = 0; alu_data = 0;
    mem_valid = 0; mem_addr = 0; mem_data = 0;
    rsv_valid = 0; rsv_addr = 0;
  endtask

  task automatic test_reset();
    idle();
    nClear = 0;
    alu_valid = 1; alu_addr = 3; alu_data = 16'h1111;
    tick(); tick();
    checks++; if ({load, Caddr, C} !== 21'd0) begin errors++; $display("FAIL reset_port: got load=%b Caddr=%0d C=%h expected all 0", load, Caddr, C); end
    checks++; if (pending !== 16'h0) begin errors++; $display("FAIL reset_pending: got %h expected 0000", pending); end
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL reset_mem_ready: got %b expected 0", mem_ready); end
    checks++; if (alu_stall !== 1'b0) begin errors++; $display("FAIL reset_alu_stall: got %b expected 0", alu_stall); end
    nClear = 1; alu_valid = 0;
    #1;
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL release_mem_ready: got %b expected 1", mem_ready); end
  endtask

  task automatic test_alu_write();
    rsv_valid = 1; rsv_addr = 3;
    tick();
    rsv_valid = 0;
    checks++; if (pending[3] !== 1'b1) begin errors++; $display("FAIL alu_rsv_set: got pending[3]=%b expected 1", pending[3]); end
    alu_valid = 1; alu_addr = 3; alu_data = 16'hBEEF;
    exp_q.push_back({4'd3, 16'hBEEF});
    tick();
    idle();
    checks++; if ({load, Caddr, C} !== {1'b1, 4'd3, 16'hBEEF}) begin errors++; $display("FAIL alu_write: got load=%b Caddr=%0d C=%h expected 1/3/beef", load, Caddr, C); end
    checks++; if (pending[3] !== 1'b0) begin errors++; $display("FAIL alu_pending_clr: got pending[3]=%b expected 0", pending[3]); end
    tick();
    checks++; if ({load, Caddr, C} !== {1'b0, 4'd3, 16'hBEEF}) begin errors++; $display("FAIL alu_hold: got load=%b Caddr=%0d C=%h expected 0/3/beef", load, Caddr, C); end
    tick();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL alu_drain: got %0d writes outstanding expected 0", exp_q.size()); end
  endtask

  task automatic test_mem_latency();
    mem_valid = 1; mem_addr = 12; mem_data = 16'h0C0C;
    #1;
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL lat_ready: got %b expected 1", mem_ready); end
    exp_q.push_back({4'd12, 16'h0C0C});
    tick();
    idle();
    checks++; if (load !== 1'b0) begin errors++; $display("FAIL lat_push_edge: got load=%b expected 0", load); end
    tick();
    checks++; if ({load, Caddr, C} !== {1'b1, 4'd12, 16'h0C0C}) begin errors++; $display("FAIL lat_write: got load=%b Caddr=%0d C=%h expected 1/12/0c0c", load, Caddr, C); end
    tick();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL lat_drain: got %0d writes outstanding expected 0", exp_q.size()); end
  endtask

  task automatic test_mem_contention();
    logic [7:0] stall_m;
    int k;
    stall_m = 8'b0010_0000;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      alu_valid = 1; alu_addr = 4'(1 + k % 6); alu_data = 16'(16'h1000 + k);
      mem_valid = (i == 0); mem_addr = 7; mem_data = 16'h00A5;
      #1;
      checks++; if (alu_stall !== stall_m[i]) begin errors++; $display("FAIL cont_stall[%0d]: got %b expected %b", i, alu_stall, stall_m[i]); end
      checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL cont_ready[%0d]: got %b expected 1", i, mem_ready); end
      if (mem_valid) mem_model_q.push_back({mem_addr, mem_data});
      if (stall_m[i]) exp_q.push_back(mem_model_q.pop_front());
      else begin exp_q.push_back({alu_addr, alu_data}); k++; end
      tick();
    end
    idle();
    tick(); tick();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL cont_drain: got %0d writes outstanding expected 0", exp_q.size()); end
  endtask

  task automatic test_fifo_full();
    logic [17:0] stall_m, ready_m;
    int k;
    stall_m = 18'b001000010000100000;
    ready_m = 18'b111111100001000011;
    k = 0;
    for (int i = 0; i < 18; i++) begin
      alu_valid = 1; alu_addr = 4'(1 + k % 6); alu_data = 16'(16'h2000 + k);
      mem_valid = (i <= 6);
      mem_addr = (i == 0) ? 4'd9 : (i == 1) ? 4'd10 : 4'd11;
      mem_data = (i == 0) ? 16'h1234 : (i == 1) ? 16'h5678 : 16'h9ABC;
      #1;
      checks++; if (alu_stall !== stall_m[i]) begin errors++; $display("FAIL full_stall[%0d]: got %b expected %b", i, alu_stall, stall_m[i]); end
      checks++; if (mem_ready !== ready_m[i]) begin errors++; $display("FAIL full_ready[%0d]: got %b expected %b", i, mem_ready, ready_m[i]); end
      if (mem_valid && ready_m[i]) mem_model_q.push_back({mem_addr, mem_data});
      if (stall_m[i]) exp_q.push_back(mem_model_q.pop_front());
      else begin exp_q.push_back({alu_addr, alu_data}); k++; end
      tick();
    end
    idle();
    tick(); tick();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL full_drain: got %0d writes outstanding expected 0", exp_q.size()); end
  endtask

  task automatic test_zero_reg();
    alu_valid = 1; alu_addr = 0; alu_data = 16'hFFFF;
    rsv_valid = 1; rsv_addr = 0;
    #1;
    checks++; if (alu_stall !== 1'b0) begin errors++; $display("FAIL zero_stall: got %b expected 0", alu_stall); end
    tick();
    idle();
    checks++; if (load !== 1'b0) begin errors++; $display("FAIL zero_load: got %b expected 0", load); end
    checks++; if (pending[0] !== 1'b0) begin errors++; $display("FAIL zero_pending: got %b expected 0", pending[0]); end
  endtask

  task automatic test_collision();
    rsv_valid = 1; rsv_addr = 5;
    tick();
    rsv_valid = 0;
    checks++; if (pending[5] !== 1'b1) begin errors++; $display("FAIL coll_rsv: got pending[5]=%b expected 1", pending[5]); end
    alu_valid = 1; alu_addr = 5; alu_data = 16'h5A5A;
    rsv_valid = 1; rsv_addr = 5;
    exp_q.push_back({4'd5, 16'h5A5A});
    tick();
    idle();
    checks++; if ({load, Caddr} !== {1'b1, 4'd5}) begin errors++; $display("FAIL coll_write: got load=%b Caddr=%0d expected 1/5", load, Caddr); end
    checks++; if (pending[5] !== 1'b1) begin errors++; $display("FAIL coll_set_wins: got pending[5]=%b expected 1", pending[5]); end
    alu_valid = 1; alu_addr = 5; alu_data = 16'h0005;
    exp_q.push_back({4'd5, 16'h0005});
    tick();
    idle();
    checks++; if (pending[5] !== 1'b0) begin errors++; $display("FAIL coll_clear: got pending[5]=%b expected 0", pending[5]); end
    tick(); tick();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL coll_drain: got %0d writes outstanding expected 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1; alu_addr = 4'(8 + i); alu_data = 16'(16'h1111 * i + 1);
      exp_q.push_back({alu_addr, alu_data});
      tick();
      checks++; if ({load, Caddr} !== {1'b1, 4'(8 + i)}) begin errors++; $display("FAIL b2b[%0d]: got load=%b Caddr=%0d expected 1/%0d", i, load, Caddr, 8 + i); end
    end
    idle();
    tick(); tick();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d writes outstanding expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_midop();
    alu_valid = 1; alu_addr = 1; alu_data = 16'hAAAA;
    mem_valid = 1; mem_addr = 13; mem_data = 16'hD00D;
    rsv_valid = 1; rsv_addr = 4;
    exp_q.push_back({4'd1, 16'hAAAA});
    tick();
    alu_addr = 2; alu_data = 16'hBBBB;
    mem_addr = 14; mem_data = 16'hE00E;
    rsv_valid = 0;
    exp_q.push_back({4'd2, 16'hBBBB});
    tick();
    checks++; if (pending[4] !== 1'b1) begin errors++; $display("FAIL midrst_rsv: got pending[4]=%b expected 1", pending[4]); end
    nClear = 0; mem_valid = 0;
    alu_addr = 3; alu_data = 16'hCCCC;
    tick();
    checks++; if ({load, Caddr, C} !== 21'd0) begin errors++; $display("FAIL midrst_port: got load=%b Caddr=%0d C=%h expected all 0", load, Caddr, C); end
    checks++; if (pending !== 16'h0) begin errors++; $display("FAIL midrst_pending: got %h expected 0000", pending); end
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b expected 0", mem_ready); end
    nClear = 1;
    idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (load !== 1'b0) begin errors++; $display("FAIL midrst_flushed[%0d]: got load=%b expected 0", i, load); end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL midrst_drain: got %0d writes outstanding expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    mon_en = 1'b1;
    test_alu_write();
    test_mem_latency();
    test_mem_contention();
    test_fifo_full();
    test_zero_reg();
    test_collision();
    test_back_to_back();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reg_writeback_ctrl.md
Name: reg_writeback_ctrl

Overview:
- Write-side controller for the 16x16 register file.
- Merges ALU results (single-cycle, highest priority) and memory-load results (buffered, ready/valid) into the register file's single write port (Caddr, C, load).
- Keeps a pending-write scoreboard so issue logic can stall on outstanding destinations.
- Sits between the execute/memory stages and the register file write port.

Parameters:
- ADDR_W, 4, register address width (16 registers).
- DATA_W, 16, register data width.
- FIFO_DEPTH, 2, memory-result buffer entries (power of 2, min 2).
- STARVE_LIMIT, 4, consecutive ALU wins tolerated while the FIFO is non-empty.

Ports:
- clk  in  1  system clock, rising edge.
- nClear  in  1  synchronous active-low reset.
- alu_valid  in  1  ALU result present.
- alu_addr  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- alu_stall  out  1  ALU result not accepted this cycle; upstream holds it.
- mem_valid  in  1  memory result present.
- mem_ready  out  1  FIFO can accept a memory result.
- mem_addr  in  ADDR_W  load destination register.
- mem_data  in  DATA_W  load data.
- rsv_valid  in  1  issue reserves a destination.
- rsv_addr  in  ADDR_W  reserved destination.
- Caddr  out  ADDR_W  register file write address.
- C  out  DATA_W  register file write data.
- load  out  1  register file write enable.
- pending  out  16  one bit per register with an outstanding write.

Behaviour:
- Reset (nClear=0 at a rising edge): load=0, Caddr=0, C=0, pending=0, FIFO empty, starve counter=0.
- mem_ready=0 and alu_stall=0 while nClear=0.
- mem_ready = nClear && (count < FIFO_DEPTH). It is combinational from registered state and independent of a same-cycle pop.
- Memory path: push when mem_valid && mem_ready. Results always pass through the FIFO. Minimum latency is 2 cycles (push edge, then select/register edge).
- Arbitration is evaluated each cycle; the winner is registered onto Caddr/C/load at the next edge, so the register file captures it one edge later.
  - alu_stall = alu_valid && fifo_nonempty && (starve_cnt == STARVE_LIMIT).
  - If alu_valid && !alu_stall: ALU wins (1-cycle latency to load).
  - Else if FIFO non-empty: pop the head.
  - Else: load=0; Caddr and C hold their previous values.
- Starve counter:
  - Increments when the ALU wins while the FIFO is non-empty.
  - Clears on any FIFO pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- Same-edge push and pop are both allowed; count is unchanged and FIFO order is preserved.
- Address 0 is the hardwired zero register.
  - A winning entry with addr 0 is consumed (ALU accepted or FIFO popped) but load=0 that cycle.
  - rsv_valid with rsv_addr=0 is ignored.
- Scoreboard:
  - A bit is set at the edge where rsv_valid is sampled.
  - A bit is cleared at the edge where the winning write to that address is registered.
  - Set and clear of the same address on the same edge: set wins.
  - Reserving an already-pending address leaves the bit set; no count is kept. Issue logic must not reserve a pending register.
- WAW ordering between ALU and memory results to the same register is enforced upstream via pending. This block does not reorder or check it.
- Reset mid-operation: FIFO contents and pending bits are discarded. No write is issued on the reset edge.

Decomposition:
- Shared package holds:
  - ADDR_W, DATA_W, NUM_REGS=16.
  - ZERO_ADDR=0.
  - Write-source enum: SRC_NONE, SRC_ALU, SRC_MEM.
- One sub-module: wb_fifo, a synchronous FIFO with push/pop/count, sync active-low clear, width ADDR_W+DATA_W, depth FIFO_DEPTH.
- Arbitration, starve counter and scoreboard stay in the top level.

Test Plan:
- Reset: hold nClear=0 for 2 cycles with alu_valid=1 -> load=0, Caddr=0, C=0, pending=0, mem_ready=0. After release, mem_ready=1.
- ALU write: alu_valid=1, alu_addr=3, alu_data=16'hBEEF at edge N -> at edge N+1 load=1, Caddr=3, C=16'hBEEF. A prior rsv to 3 makes pending[3] drop at edge N+1.
- Memory path with contention:
  - Push mem (addr 7, 16'h00A5) at edge N while ALU is continuously valid.
  - After 4 ALU wins, alu_stall=1 for one cycle.
  - Memory write appears with Caddr=7, C=16'h00A5, load=1 on the following edge, then the ALU resumes.
- FIFO full: with the ALU continuously valid, push mem (addr 9, 16'h1234) then mem (addr 10, 16'h5678) on consecutive edges (2 pushes) -> mem_ready=0 while full. After the 4 ALU wins, alu_stall=1 and addr 9 pops; mem_ready=1 the next cycle. A third mem_valid held while mem_ready=0 is not lost.
- Zero register: ALU write to addr 0 with data 16'hFFFF, plus rsv to addr 0 -> load stays 0, pending[0] stays 0, no stall.
- Scoreboard collision: pending[5]=1; same edge sees an ALU write to 5 being registered and rsv_valid to 5 -> load=1, Caddr=5, and pending[5] remains 1.
